multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control state machine for the multicycle RV32I core. Sequences the shared ALU,
//  memory port and register file across FETCH/DECODE/EXECUTE/MEM/WB cycles.
//  Drives ALUOp into alu_decoder and the datapath mux selects and enables.
//  Sits beside alu_decoder and the immediate decoder inside the controller.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: memory states wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk            in   1  core clock, rising edge
//  reset          in   1  asynchronous, active-high; returns FSM to FETCH
//  op             in   7  instr[6:0] from instruction register
//  mem_ready      in   1  memory access completes this cycle
//  PCUpdate       out  1  unconditional PC write enable
//  Branch         out  1  conditional PC write (datapath: PCWrite = PCUpdate | Branch&Zero)
//  AdrSrc         out  1  mem address: 0 PC, 1 Result
//  MemWrite       out  1  data memory write enable
//  IRWrite        out  1  instruction register / OldPC load
//  RegWrite       out  1  register file write enable
//  ResultSrc      out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//  ALUSrcA        out  2  00 PC, 01 OldPC, 10 rs1 register A
//  ALUSrcB        out  2  00 rs2 WriteData, 01 ImmExt, 10 constant 4
//  ALUOp          out  2  00 add, 01 sub, 10 decode funct3/funct7
//  retire         out  1  1-cycle pulse in final state of each instruction
//  illegal_instr  out  1  1-cycle pulse in DECODE on unsupported opcode
//  state_dbg      out  4  current state encoding
// BEHAVIOUR
//  - Registered state, Moore outputs; unlisted outputs are 0. Reset: state=FETCH=4'd0;
//    while reset is high, all enables, retire and illegal_instr are forced to 0.
//  - FETCH(0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
//    IRWrite=PCUpdate=mem_ready. Stays in FETCH while !mem_ready; mem_ready -> DECODE.
//  - DECODE(1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (ALUOut=OldPC+imm). Next state by op:
//    0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH,
//    1101111->JAL, 1100111->JALR, 0110111->LUI, 0010111->ALUWB, other->FETCH plus illegal_instr.
//  - MEMADR(2): ALUSrcA=10, ALUSrcB=01, ALUOp=00; lw->MEMREAD, sw->MEMWRITE.
//  - MEMREAD(3): ResultSrc=00, AdrSrc=1; waits for mem_ready, then -> MEMWB.
//  - MEMWB(4): ResultSrc=01, RegWrite=1, retire=1 -> FETCH.
//  - MEMWRITE(5): ResultSrc=00, AdrSrc=1, MemWrite=1 held until mem_ready;
//    retire=mem_ready; then -> FETCH.
//  - EXECR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
//    EXECI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
//  - ALUWB(8): ResultSrc=00, RegWrite=1, retire=1 -> FETCH.
//  - BRANCH(9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1 -> FETCH.
//  - JAL(10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
//  - JALR(11): ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1 -> JLINK.
//    JLINK(12): ALUSrcA=01, ALUSrcB=10, ALUOp=00 (ALUOut=OldPC+4) -> ALUWB.
//  - LUI(13): ResultSrc=11, RegWrite=1, retire=1 -> FETCH.
//  - Encodings 14-15 are unreachable; if entered, outputs are 0 and next state is FETCH.
//  - Latency with mem_ready=1: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3, auipc 3 cycles.
//    Each memory wait cycle adds 1 cycle.
//  - MEM_HANDSHAKE=0: FETCH, MEMREAD and MEMWRITE always advance after 1 cycle.
//  - Async reset mid-instruction: state is FETCH immediately; no partial write is
//    asserted after reset rises.
// TESTING
//  - Reset: assert mid-EXECR -> state_dbg=0 same cycle, RegWrite=0; release -> FETCH, IRWrite=1.
//  - add (op=0110011), mem_ready=1 -> states 0,1,6,8; ALUOp=10 in EXECR; RegWrite and retire in cycle 4.
//  - lw, mem_ready low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4; RegWrite only in MEMWB.
//  - sw with mem_ready=0 for 3 cycles -> MemWrite held 4 cycles, retire on 4th, then FETCH.
//  - beq -> 0,1,9; Branch=1, ALUOp=01 in BRANCH. jalr -> 0,1,11,12,8; PCUpdate in JALR only.
//  - op=7'b1111111 -> illegal_instr pulses in DECODE, then FETCH; no RegWrite or MemWrite asserted.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences the shared ALU,
// memory port and register file through fetch/decode/execute/memory/writeback.
module multicycle_control_fsm #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       retire,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JLINK    = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t state;
    logic   mem_ok;
    logic   op_legal;

    // With the handshake disabled the memory is assumed to answer in one cycle.
    assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        op_legal = 1'b1;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ok) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECR;
                        OP_ITYPE:          state <= S_EXECI;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JAL;
                        OP_JALR:           state <= S_JALR;
                        OP_LUI:            state <= S_LUI;
                        OP_AUIPC:          state <= S_ALUWB;
                        default:           state <= S_FETCH;
                    endcase
                end
                // op[5] separates store (0100011) from load (0000011).
                S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ok) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_ok) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_JALR:     state <= S_JLINK;
                S_JLINK:    state <= S_ALUWB;
                S_LUI:      state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    logic pc_update_raw, branch_raw, mem_write_raw, ir_write_raw;
    logic reg_write_raw, retire_raw, illegal_raw;

    // Output decode from the state register; only FETCH and MEMWRITE look at
    // mem_ready so that their strobes coincide with the memory completing.
    always_comb begin
        pc_update_raw = 1'b0;
        branch_raw    = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        illegal_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        case (state)
            S_FETCH: begin
                ALUSrcB       = 2'b10;
                ResultSrc     = 2'b10;
                ir_write_raw  = mem_ok;
                pc_update_raw = mem_ok;
            end
            S_DECODE: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b01;
                illegal_raw = ~op_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                retire_raw    = mem_ok;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                branch_raw = 1'b1;
                retire_raw = 1'b1;
            end
            S_JAL: begin
                ALUSrcA       = 2'b01;
                ALUSrcB       = 2'b10;
                pc_update_raw = 1'b1;
            end
            S_JALR: begin
                ALUSrcA       = 2'b10;
                ALUSrcB       = 2'b01;
                ResultSrc     = 2'b10;
                pc_update_raw = 1'b1;
            end
            S_JLINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_LUI: begin
                ResultSrc     = 2'b11;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            default: begin
                AdrSrc = 1'b0;
            end
        endcase
    end

    // Reset masks every strobe so nothing is written while reset is high.
    assign PCUpdate      = pc_update_raw & ~reset;
    assign Branch        = branch_raw    & ~reset;
    assign MemWrite      = mem_write_raw & ~reset;
    assign IRWrite       = ir_write_raw  & ~reset;
    assign RegWrite      = reg_write_raw & ~reset;
    assign retire        = retire_raw    & ~reset;
    assign illegal_instr = illegal_raw   & ~reset;
    assign state_dbg     = state;

endmodule
